jtshouse_scr_fetch: RTL and testbench



---
 rtl/jtshouse_scr_pkg.sv | 22 ++
 rtl/jtshouse_scr_penc.sv | 18 +
 rtl/jtshouse_scr_fetch.sv | 166 ++++++++++++++++
 tb/tb_jtshouse_scr_fetch.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtshouse_scr_pkg.sv
// Shared constants and state type for the C123 tilemap fetch scheduler.
package jtshouse_scr_pkg;

  localparam int unsigned NLYR    = 6;
  localparam int unsigned LyrIdxW = 3;
  localparam int unsigned TmapAw  = 14;
  localparam int unsigned TmapDw  = 16;
  localparam int unsigned RowW    = 3;
  localparam int unsigned CodeW   = 14;
  localparam int unsigned MaskAw  = CodeW + RowW;
  localparam int unsigned MaskDw  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StWait0,
    StWait,
    StAck
  } scr_st_e;

endpackage

// File: rtl/jtshouse_scr_penc.sv
// Lowest-index-wins priority encoder over the per-layer pending bits.
module jtshouse_scr_penc
  import jtshouse_scr_pkg::*;
(
  input  logic [NLYR-1:0]    req_i,
  output logic               valid_o,
  output logic [LyrIdxW-1:0] idx_o
);

  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    for (int i = int'(NLYR) - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = LyrIdxW'(i);
    end
  end

endmodule

// File: rtl/jtshouse_scr_fetch.sv
// Tile fetch scheduler: arbitrates layer reload requests and sequences the
// tilemap BRAM read followed by the mask SDRAM read, one layer at a time.
module jtshouse_scr_fetch
  import jtshouse_scr_pkg::*;
#(
  parameter int unsigned MISSW = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hs_i,
  input  logic [NLYR-1:0]        req_set_i,
  input  logic [NLYR*TmapAw-1:0] lyr_addr_i,
  input  logic [NLYR*RowW-1:0]   lyr_sub_i,
  output logic [TmapAw-1:0]      tmap_addr_o,
  input  logic [TmapDw-1:0]      tmap_data_i,
  output logic [MaskAw-1:0]      mask_addr_o,
  output logic                   mask_cs_o,
  input  logic                   mask_ok_i,
  input  logic [MaskDw-1:0]      mask_data_i,
  output logic [NLYR-1:0]        ack_o,
  output logic [CodeW-1:0]       ack_code_o,
  output logic [MaskDw-1:0]      ack_mask_o,
  output logic                   busy_o,
  output logic [MISSW-1:0]       miss_cnt_o
);

  scr_st_e              state_q, state_d;
  logic [NLYR-1:0]      pend_q, pend_d;
  logic                 rereq_q, rereq_d;
  logic [LyrIdxW-1:0]   g_q, g_d;
  logic [RowW-1:0]      row_q, row_d;
  logic [TmapAw-1:0]    tmap_addr_q, tmap_addr_d;
  logic [CodeW-1:0]     code_q, code_d;
  logic [MaskAw-1:0]    mask_addr_q, mask_addr_d;
  logic                 mask_cs_q, mask_cs_d;
  logic [NLYR-1:0]      ack_q, ack_d;
  logic [CodeW-1:0]     ack_code_q, ack_code_d;
  logic [MaskDw-1:0]    ack_mask_q, ack_mask_d;
  logic [MISSW-1:0]     miss_q, miss_d;
  logic                 hs_q;

  logic                 hs_rise;
  logic                 grant_vld;
  logic [LyrIdxW-1:0]   grant_idx;
  logic [NLYR-1:0]      grant_oh;
  logic                 unused_tmap_hi;

  assign hs_rise        = hs_i & ~hs_q;
  assign grant_oh       = NLYR'(1) << g_q;
  assign unused_tmap_hi = ^tmap_data_i[TmapDw-1:CodeW];

  jtshouse_scr_penc u_penc (
    .req_i   (pend_q),
    .valid_o (grant_vld),
    .idx_o   (grant_idx)
  );

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    rereq_d     = rereq_q;
    g_d         = g_q;
    row_d       = row_q;
    tmap_addr_d = tmap_addr_q;
    code_d      = code_q;
    mask_addr_d = mask_addr_q;
    mask_cs_d   = mask_cs_q;
    ack_d       = '0;
    ack_code_d  = ack_code_q;
    ack_mask_d  = ack_mask_q;
    miss_d      = miss_q;

    if (hs_rise) begin
      // Line is over: drop everything, including requests arriving this cycle.
      state_d   = StIdle;
      pend_d    = '0;
      rereq_d   = 1'b0;
      mask_cs_d = 1'b0;
      if ((|pend_q || state_q != StIdle) && miss_q != '1) begin
        miss_d = miss_q + MISSW'(1);
      end
    end else begin
      pend_d = pend_q | req_set_i;
      unique case (state_q)
        StIdle: begin
          if (grant_vld) begin
            g_d         = grant_idx;
            tmap_addr_d = lyr_addr_i[TmapAw*32'(grant_idx) +: TmapAw];
            row_d       = lyr_sub_i[RowW*32'(grant_idx) +: RowW];
            rereq_d     = 1'b0;
            state_d     = StAddr;
          end
        end
        StAddr: state_d = StData;
        StData: begin
          code_d      = tmap_data_i[CodeW-1:0];
          mask_addr_d = {tmap_data_i[CodeW-1:0], row_q};
          mask_cs_d   = 1'b1;
          state_d     = StWait0;
        end
        // First cycle after mask_cs may still see the previous slot's ok.
        StWait0: state_d = StWait;
        StWait: begin
          if (mask_ok_i) begin
            mask_cs_d  = 1'b0;
            ack_d      = grant_oh;
            ack_code_d = code_q;
            ack_mask_d = mask_data_i;
            state_d    = StAck;
          end
        end
        StAck: begin
          if (!rereq_q) pend_d = (pend_q & ~grant_oh) | req_set_i;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
      // A repeat request for the layer being served must survive its ack.
      if (state_q != StIdle && |(req_set_i & grant_oh)) rereq_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pend_q      <= '0;
      rereq_q     <= 1'b0;
      g_q         <= '0;
      row_q       <= '0;
      tmap_addr_q <= '0;
      code_q      <= '0;
      mask_addr_q <= '0;
      mask_cs_q   <= 1'b0;
      ack_q       <= '0;
      ack_code_q  <= '0;
      ack_mask_q  <= '0;
      miss_q      <= '0;
      hs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      rereq_q     <= rereq_d;
      g_q         <= g_d;
      row_q       <= row_d;
      tmap_addr_q <= tmap_addr_d;
      code_q      <= code_d;
      mask_addr_q <= mask_addr_d;
      mask_cs_q   <= mask_cs_d;
      ack_q       <= ack_d;
      ack_code_q  <= ack_code_d;
      ack_mask_q  <= ack_mask_d;
      miss_q      <= miss_d;
      hs_q        <= hs_i;
    end
  end

  assign tmap_addr_o = tmap_addr_q;
  assign mask_addr_o = mask_addr_q;
  assign mask_cs_o   = mask_cs_q;
  assign ack_o       = ack_q;
  assign ack_code_o  = ack_code_q;
  assign ack_mask_o  = ack_mask_q;
  assign busy_o      = |pend_q || state_q != StIdle;
  assign miss_cnt_o  = miss_q;

endmodule

// File: tb/tb_jtshouse_scr_fetch.sv
// Directed bench for the tile fetch scheduler with a transaction-level reference model.
module tb_jtshouse_scr_fetch;

  logic        clk;
  logic        rst_n;
  logic        hs;
  logic [5:0]  req_set;
  logic [83:0] lyr_addr;
  logic [17:0] lyr_sub;
  logic [13:0] tmap_addr;
  logic [15:0] tmap_data;
  logic [16:0] mask_addr;
  logic        mask_cs;
  logic        mask_ok;
  logic [7:0]  mask_data;
  logic [5:0]  ack;
  logic [13:0] ack_code;
  logic [7:0]  ack_mask;
  logic        busy;
  logic [7:0]  miss_cnt;

  logic [13:0] la [6];
  logic [2:0]  ls [6];

  int total = 0;
  int bad   = 0;

  jtshouse_scr_fetch #(.MISSW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hs_i        (hs),
    .req_set_i   (req_set),
    .lyr_addr_i  (lyr_addr),
    .lyr_sub_i   (lyr_sub),
    .tmap_addr_o (tmap_addr),
    .tmap_data_i (tmap_data),
    .mask_addr_o (mask_addr),
    .mask_cs_o   (mask_cs),
    .mask_ok_i   (mask_ok),
    .mask_data_i (mask_data),
    .ack_o       (ack),
    .ack_code_o  (ack_code),
    .ack_mask_o  (ack_mask),
    .busy_o      (busy),
    .miss_cnt_o  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] bram(input logic [13:0] a);
    logic [15:0] w;
    w = {2'b10, a ^ 14'h02A5};
    if (a == 14'h1A3C) w = 16'h0123;
    return w;
  endfunction

  always @(posedge clk) tmap_data <= bram(tmap_addr);

  always_comb begin
    lyr_addr = '0;
    lyr_sub  = '0;
    for (int k = 0; k < 6; k++) begin
      lyr_addr[14*k +: 14] = la[k];
      lyr_sub[3*k +: 3]    = ls[k];
    end
  end

  typedef struct packed {
    logic [5:0]  pend;
    logic        inflight;
    logic        acking;
    logic [7:0]  age;
    logic [2:0]  g;
    logic        rereq;
    logic [13:0] tmap;
    logic [2:0]  row;
    logic [13:0] code;
    logic [16:0] maddr;
    logic        cs;
    logic [5:0]  ack;
    logic [13:0] acode;
    logic [7:0]  amask;
    logic [7:0]  miss;
    logic        hsp;
  } model_t;

  model_t m;

  // One clock of the scheduler's observable behaviour.
  function automatic model_t step(input model_t c, input logic h, input logic [5:0] rq,
                                  input logic ok, input logic [7:0] md);
    model_t n;
    logic [15:0] word;
    logic [5:0] gbit;
    n     = c;
    n.hsp = h;
    n.ack = '0;
    gbit  = 6'b1 << c.g;
    if (h && !c.hsp) begin
      if (c.pend != 0 || c.inflight) n.miss = (c.miss == 8'hFF) ? 8'hFF : c.miss + 8'd1;
      n.pend     = '0;
      n.inflight = 1'b0;
      n.acking   = 1'b0;
      n.cs       = 1'b0;
      n.rereq    = 1'b0;
      return n;
    end
    if (c.acking) begin
      n.acking   = 1'b0;
      n.inflight = 1'b0;
      if (!c.rereq) n.pend = c.pend & ~gbit;
    end else if (c.inflight) begin
      if (c.age != 8'hFF) n.age = c.age + 8'd1;
      if (c.age == 8'd2) begin
        word    = bram(c.tmap);
        n.code  = word[13:0];
        n.maddr = {word[13:0], c.row};
        n.cs    = 1'b1;
      end
      if (c.age >= 8'd4 && ok) begin
        n.cs     = 1'b0;
        n.ack    = gbit;
        n.acode  = c.code;
        n.amask  = md;
        n.acking = 1'b1;
      end
    end else if (c.pend != 0) begin
      for (int i = 5; i >= 0; i--) if (c.pend[i]) n.g = 3'(i);
      n.tmap     = la[n.g];
      n.row      = ls[n.g];
      n.inflight = 1'b1;
      n.age      = 8'd1;
      n.rereq    = 1'b0;
    end
    if (c.inflight && (rq & gbit) != 0) n.rereq = 1'b1;
    n.pend = n.pend | rq;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= step(m, hs, req_set, mask_ok, mask_data);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_tmap_addr", 32'(tmap_addr), 32'(m.tmap));
    chk("m_mask_addr", 32'(mask_addr), 32'(m.maddr));
    chk("m_mask_cs",   32'(mask_cs),   32'(m.cs));
    chk("m_ack",       32'(ack),       32'(m.ack));
    chk("m_ack_code",  32'(ack_code),  32'(m.acode));
    chk("m_ack_mask",  32'(ack_mask),  32'(m.amask));
    chk("m_busy",      32'(busy),      32'(|m.pend | m.inflight));
    chk("m_miss_cnt",  32'(miss_cnt),  32'(m.miss));
  end

  // Pulses req at the current negedge, then waits for an ack counting cycles from the request.
  task automatic fetch(input logic [5:0] rq, input int ok_lo, input int ok_hi, input int pulse_at,
                       output int lat, output logic [5:0] got);
    int k;
    req_set = rq;
    mask_ok = (ok_lo == 0) ? 1'b1 : 1'b0;
    k = 0;
    got = '0;
    lat = -1;
    while (k < 40 && lat < 0) begin
      @(negedge clk);
      k++;
      req_set = '0;
      if (ack != 0) begin
        lat = k;
        got = ack;
      end
      mask_ok = (k >= ok_hi) || (k == pulse_at) || (ok_lo == 0);
    end
    if (lat < 0) chk("ack_timeout", 32'd0, 32'd1);
    mask_ok = 1'b1;
  endtask

  int lat;
  logic [5:0] got;
  int ack_k [4];
  logic [5:0] ack_v [4];
  int n_ack;

  initial begin
    rst_n = 1'b0;
    hs = 1'b0;
    req_set = '0;
    mask_ok = 1'b1;
    mask_data = 8'hF0;
    for (int k = 0; k < 6; k++) begin
      la[k] = 14'(14'h0400 * k + 14'h0011 + k);
      ls[k] = 3'(k);
    end
    la[2] = 14'h1A3C;
    ls[2] = 3'd5;
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cs", 32'(mask_cs), 32'd0);
    chk("rst_miss", 32'(miss_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request on layer 2.
    fetch(6'b000100, 0, 0, -1, lat, got);
    chk("single_lat", 32'(lat), 32'd6);
    chk("single_ack", 32'(got), 32'h04);
    chk("single_code", 32'(ack_code), 32'h0123);
    chk("single_mask", 32'(ack_mask), 32'hF0);
    chk("single_maddr", 32'(mask_addr), 32'h0091D);
    @(negedge clk);
    chk("single_ack_clr", 32'(ack), 32'd0);
    chk("single_code_hold", 32'(ack_code), 32'h0123);
    chk("single_idle", 32'(busy), 32'd0);

    // Priority: 0,4,5 then 1 arrives mid-fetch.
    req_set = 6'b110001;
    n_ack = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      req_set = (k == 2) ? 6'b000010 : 6'b000000;
      if (ack != 0 && n_ack < 4) begin
        ack_k[n_ack] = k;
        ack_v[n_ack] = ack;
        n_ack++;
      end
    end
    chk("prio_count", 32'(n_ack), 32'd4);
    chk("prio_k0", 32'(ack_k[0]), 32'd6);
    chk("prio_v0", 32'(ack_v[0]), 32'h01);
    chk("prio_k1", 32'(ack_k[1]), 32'd12);
    chk("prio_v1", 32'(ack_v[1]), 32'h02);
    chk("prio_k2", 32'(ack_k[2]), 32'd18);
    chk("prio_v2", 32'(ack_v[2]), 32'h10);
    chk("prio_k3", 32'(ack_k[3]), 32'd24);
    chk("prio_v3", 32'(ack_v[3]), 32'h20);

    // Slow SDRAM: ok only from cycle t+15.
    mask_data = 8'h3C;
    fetch(6'b000001, 1, 15, -1, lat, got);
    chk("slow_lat", 32'(lat), 32'd16);
    chk("slow_mask", 32'(ack_mask), 32'h3C);

    // A lone ok pulse in WAIT0 must not complete the fetch.
    mask_data = 8'hA5;
    fetch(6'b000001, 1, 8, 4, lat, got);
    chk("wait0_lat", 32'(lat), 32'd9);
    chk("wait0_mask", 32'(ack_mask), 32'hA5);

    // Re-request of the in-flight layer gets a second fetch.
    req_set = 6'b000001;
    n_ack = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      req_set = (k == 3) ? 6'b000001 : 6'b000000;
      if (ack != 0 && n_ack < 4) begin
        ack_k[n_ack] = k;
        n_ack++;
      end
    end
    chk("rereq_count", 32'(n_ack), 32'd2);
    chk("rereq_k1", 32'(ack_k[1]), 32'd12);

    // Flush during WAIT.
    req_set = 6'b001000;
    mask_ok = 1'b0;
    n_ack = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      req_set = '0;
      if (ack != 0) n_ack++;
      if (k == 5) chk("flush_cs_before", 32'(mask_cs), 32'd1);
      hs = (k == 5);
      if (k == 6) begin
        chk("flush_cs", 32'(mask_cs), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_miss", 32'(miss_cnt), 32'd1);
      end
      if (k >= 7) mask_ok = 1'b1;
    end
    chk("flush_noack", 32'(n_ack), 32'd0);

    // hs edge together with a request: request dropped, idle line not counted.
    hs = 1'b1;
    req_set = 6'b000010;
    @(negedge clk);
    hs = 1'b0;
    req_set = '0;
    @(negedge clk);
    chk("hsreq_busy", 32'(busy), 32'd0);
    chk("hsreq_miss", 32'(miss_cnt), 32'd1);

    // hs edge during the ACK cycle: ack still visible, line counted.
    req_set = 6'b000001;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req_set = '0;
      if (k == 6) chk("hsack_ack", 32'(ack), 32'h01);
      hs = (k == 6);
      if (k == 7) begin
        chk("hsack_busy", 32'(busy), 32'd0);
        chk("hsack_miss", 32'(miss_cnt), 32'd2);
      end
    end

    // Saturation.
    for (int i = 0; i < 260; i++) begin
      req_set = 6'b000100;
      @(negedge clk);
      req_set = '0;
      hs = 1'b1;
      @(negedge clk);
      hs = 1'b0;
    end
    chk("sat_ff", 32'(miss_cnt), 32'hFF);
    req_set = 6'b000001;
    @(negedge clk);
    req_set = '0;
    hs = 1'b1;
    @(negedge clk);
    hs = 1'b0;
    @(negedge clk);
    chk("sat_hold", 32'(miss_cnt), 32'hFF);

    // Reset mid-fetch.
    req_set = 6'b000001;
    mask_ok = 1'b0;
    @(negedge clk);
    req_set = '0;
    repeat (5) @(negedge clk);
    chk("rstmid_cs_before", 32'(mask_cs), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_cs", 32'(mask_cs), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_miss", 32'(miss_cnt), 32'd0);
    chk("rstmid_tmap", 32'(tmap_addr), 32'd0);
    chk("rstmid_maddr", 32'(mask_addr), 32'd0);
    chk("rstmid_code", 32'(ack_code), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mask_ok = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstmid_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
